ffe_tdm_param: RTL and testbench

Parametrised successor to the fixed 4-tap single-multiplier FFE. It is a time-multiplexed FIR feed-forward equaliser with a generic tap count, data width and coefficient width. Coefficients are runtime-programmable and double-buffered. It has a valid/ready sample handshake, output saturation and a flush control. All taps share one multiplier and one accumulator, and everything runs on the FFE clock domain.

---
 rtl/ffe_tdm_param.sv | 255 +++++++++++++++++++++++++
 tb/tb_ffe_tdm_param.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ffe_tdm_param.sv
// ---------------------------------------------------------------------------
// ffe_tdm_param
//
// Time-multiplexed FIR feed-forward equaliser. A single multiplier and a
// single accumulator are shared across all taps: after a sample is accepted
// the block spends TAPS cycles walking the delay line (one MAC per cycle),
// then one cycle scaling/saturating and registering the result.
//
// Coefficients are double-buffered. Writes always land in the shadow bank.
// A commit request copies shadow -> active only when the datapath is idle
// and no sample is being accepted, so a sample in flight always sees one
// consistent coefficient set.
//
// Parameters
//   DATA_W     signed sample / result width
//   COEF_W     signed coefficient width
//   TAPS       number of taps (2..16)
//   FRAC_BITS  coefficient fractional bits (FRAC_BITS <= COEF_W-2)
//
// Ports
//   ffe_clk      clock, rising edge
//   rst          asynchronous active-high reset
//   flush        synchronous clear of delay line / accumulator / pending commit
//   in_valid     d_in carries a sample
//   in_ready     block is idle and will take a sample this cycle
//   d_in         signed input sample
//   coef_we      write coef_wdata into shadow tap coef_addr
//   coef_addr    shadow tap index (indices >= TAPS are ignored)
//   coef_wdata   signed coefficient
//   coef_commit  request shadow -> active copy
//   y            saturated signed result, held between results
//   y_valid      one-cycle pulse when y is new
//   sat          result was clamped (meaningful with y_valid)
// ---------------------------------------------------------------------------
module ffe_tdm_param #(
    parameter int DATA_W    = 12,
    parameter int COEF_W    = 12,
    parameter int TAPS      = 4,
    parameter int FRAC_BITS = 10
) (
    input  logic                      ffe_clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  d_in,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_wdata,
    input  logic                      coef_commit,
    output logic signed [DATA_W-1:0]  y,
    output logic                      y_valid,
    output logic                      sat
);

    localparam int KW     = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + KW;

    // 1.0 in the coefficient's fixed-point format
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << FRAC_BITS;

    // Output clamp limits, both at accumulator width for the range test and
    // at output width for the clamped value itself.
    localparam logic signed [ACC_W-1:0] Y_MAX_ACC =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN_ACC =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                    state_reg;
    logic [KW-1:0]             k_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic                      pending_reg;
    logic signed [DATA_W-1:0]  y_reg;
    logic                      y_valid_reg;
    logic                      sat_reg;

    logic signed [DATA_W-1:0]  x_reg      [TAPS];
    logic signed [COEF_W-1:0]  shadow_reg [TAPS];
    logic signed [COEF_W-1:0]  active_reg [TAPS];

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    logic accept;
    logic copy_en;
    logic [TAPS-1:0] wr_hit;

    assign in_ready = (state_reg == IDLE);

    // flush outranks everything, including an accept in the same cycle
    assign accept = in_valid & in_ready & ~flush;

    // The copy may fire in the same cycle the commit is requested if the
    // datapath is idle; otherwise the pending flag carries the request until
    // the first idle cycle that is not an accept.
    assign copy_en = (pending_reg | coef_commit) & in_ready & ~accept & ~flush;

    // Per-tap shadow write strobes. An out-of-range address matches no tap,
    // so the write simply drops.
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : gen_wr_hit
            assign wr_hit[gi] = coef_we & ~flush & (coef_addr == KW'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Shared multiplier and result scaling
    // -----------------------------------------------------------------------
    logic signed [DATA_W-1:0] x_sel;
    logic signed [COEF_W-1:0] c_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic                     over;
    logic                     under;
    logic signed [DATA_W-1:0] y_next;

    assign x_sel    = x_reg[k_reg];
    assign c_sel    = active_reg[k_reg];
    assign prod     = PROD_W'(x_sel) * PROD_W'(c_sel);
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // Arithmetic shift gives floor division by 2^FRAC_BITS (no rounding)
    assign shifted = acc_reg >>> FRAC_BITS;
    assign over    = (shifted > Y_MAX_ACC);
    assign under   = (shifted < Y_MIN_ACC);

    always_comb begin
        y_next = shifted[DATA_W-1:0];
        if (over) begin
            y_next = Y_MAX;
        end else if (under) begin
            y_next = Y_MIN;
        end
    end

    // -----------------------------------------------------------------------
    // Delay line: shifts only on accept, so MAC always reads a stable window
    // -----------------------------------------------------------------------
    always_ff @(posedge ffe_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                x_reg[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < TAPS; i++) begin
                x_reg[i] <= '0;
            end
        end else if (accept) begin
            x_reg[0] <= d_in;
            for (int i = 1; i < TAPS; i++) begin
                x_reg[i] <= x_reg[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Coefficient banks. The copy reads the shadow value from before any
    // same-cycle write, which falls out of non-blocking assignment order.
    // -----------------------------------------------------------------------
    always_ff @(posedge ffe_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                shadow_reg[i] <= (i == 0) ? COEF_ONE : '0;
                active_reg[i] <= (i == 0) ? COEF_ONE : '0;
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                if (wr_hit[i]) begin
                    shadow_reg[i] <= coef_wdata;
                end
                if (copy_en) begin
                    active_reg[i] <= shadow_reg[i];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer: IDLE -> MAC (TAPS cycles) -> OUT -> IDLE
    // -----------------------------------------------------------------------
    always_ff @(posedge ffe_clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            k_reg       <= '0;
            acc_reg     <= '0;
            pending_reg <= 1'b0;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
            sat_reg     <= 1'b0;
        end else if (flush) begin
            // Abort: no result for the in-flight sample; y and sat keep
            // whatever the last completed result left there.
            state_reg   <= IDLE;
            k_reg       <= '0;
            acc_reg     <= '0;
            pending_reg <= 1'b0;
            y_valid_reg <= 1'b0;
        end else begin
            y_valid_reg <= 1'b0;

            if (copy_en) begin
                pending_reg <= 1'b0;
            end else if (coef_commit) begin
                pending_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        acc_reg   <= '0;
                        k_reg     <= '0;
                        state_reg <= MAC;
                    end
                end

                MAC: begin
                    acc_reg <= acc_reg + prod_ext;
                    k_reg   <= k_reg + KW'(1);
                    if (k_reg == KW'(TAPS - 1)) begin
                        state_reg <= OUT;
                    end
                end

                OUT: begin
                    y_reg       <= y_next;
                    sat_reg     <= over | under;
                    y_valid_reg <= 1'b1;
                    state_reg   <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign y       = y_reg;
    assign y_valid = y_valid_reg;
    assign sat     = sat_reg;

endmodule

// File: tb/tb_ffe_tdm_param.sv
// ---------------------------------------------------------------------------
// tb_ffe_tdm_param
//
// Directed bench for ffe_tdm_param (default parameters). A transaction-level
// model holds the sample history and both coefficient banks as plain integer
// arrays and computes each expected result as floor(sum(x*c) / 2^FRAC_BITS)
// clamped to the output range, due TAPS+1 edges after its accept. A compare
// process checks y_valid/y/sat/in_ready against the model on every falling
// edge; hand-computed literals then pin the model's results per scenario.
// ---------------------------------------------------------------------------
module tb_ffe_tdm_param;

    localparam int DATA_W    = 12;
    localparam int COEF_W    = 12;
    localparam int TAPS      = 4;
    localparam int FRAC_BITS = 10;
    localparam int KW        = $clog2(TAPS);
    localparam int LAT       = TAPS + 1;
    localparam int YMAX      = (1 << (DATA_W - 1)) - 1;
    localparam int YMIN      = -(1 << (DATA_W - 1));

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] d_in;
    logic                     coef_we;
    logic [KW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_commit;
    logic signed [DATA_W-1:0] y;
    logic                     y_valid;
    logic                     sat;

    ffe_tdm_param #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .TAPS      (TAPS),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .ffe_clk     (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .d_in        (d_in),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .y           (y),
        .y_valid     (y_valid),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // ---------------- model ----------------
    typedef struct {
        int y;
        bit s;
        int due;
    } exp_t;

    int   hist [TAPS];
    int   sh   [TAPS];
    int   act  [TAPS];
    bit   pend;
    int   ready_at;
    int   last_y;
    exp_t exp_q [$];
    int   res_y [$];
    bit   res_s [$];
    bit   started = 1'b0;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic signed [63:0] got, logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            hist[i] = 0;
            sh[i]   = (i == 0) ? (1 << FRAC_BITS) : 0;
            act[i]  = sh[i];
        end
        pend     = 1'b0;
        exp_q.delete();
        last_y   = 0;
        ready_at = edge_n;
    endfunction

    function automatic void model_result(output int r, output bit s);
        longint sum;
        longint q;
        longint div;
        sum = 0;
        div = longint'(1) << FRAC_BITS;
        for (int i = 0; i < TAPS; i++) begin
            sum += longint'(hist[i]) * longint'(act[i]);
        end
        q = sum / div;
        if (sum < 0 && (sum % div) != 0) q -= 1;
        s = 1'b0;
        if (q > YMAX) begin
            q = YMAX;
            s = 1'b1;
        end else if (q < YMIN) begin
            q = YMIN;
            s = 1'b1;
        end
        r = int'(q);
    endfunction

    // One clock edge with whatever inputs are currently driven; the model
    // applies that edge's effects afterwards.
    task automatic step();
        bit   idle;
        bit   acc;
        int   r;
        bit   s;
        exp_t e;
        idle = (edge_n >= ready_at);
        acc  = in_valid && idle && !flush;
        @(posedge clk);
        #1;
        if (flush) begin
            for (int i = 0; i < TAPS; i++) hist[i] = 0;
            exp_q.delete();
            pend     = 1'b0;
            ready_at = edge_n;
        end else begin
            if ((pend || coef_commit) && idle && !acc) begin
                act  = sh;
                pend = 1'b0;
            end else if (coef_commit) begin
                pend = 1'b1;
            end
            if (coef_we && int'(coef_addr) < TAPS) sh[coef_addr] = int'(coef_wdata);
            if (acc) begin
                for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = int'(d_in);
                model_result(r, s);
                e.y   = r;
                e.s   = s;
                e.due = edge_n + LAT;
                exp_q.push_back(e);
                ready_at = edge_n + LAT;
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("in_ready", in_ready, (edge_n >= ready_at));
            if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
                chk("y_valid_pulse", y_valid, 1);
                chk("y", y, exp_q[0].y);
                chk("sat", sat, exp_q[0].s);
                $display("txn edge=%0d y=%0d sat=%0d (model y=%0d sat=%0d)",
                         edge_n, y, sat, exp_q[0].y, exp_q[0].s);
                res_y.push_back(exp_q[0].y);
                res_s.push_back(exp_q[0].s);
                last_y = exp_q[0].y;
                void'(exp_q.pop_front());
            end else begin
                chk("y_valid_idle", y_valid, 0);
                chk("y_hold", y, last_y);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr_coef(input int a, input int v);
        coef_we    = 1'b1;
        coef_addr  = KW'(a);
        coef_wdata = COEF_W'(v);
        step();
        coef_we    = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        step();
        coef_commit = 1'b0;
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
        wr_coef(0, c0);
        wr_coef(1, c1);
        wr_coef(2, c2);
        wr_coef(3, c3);
        commit();
        repeat (2) step();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic send(input int v);
        int guard;
        guard = 0;
        while (edge_n < ready_at && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) chk("send_timeout", 1, 0);
        in_valid = 1'b1;
        d_in     = DATA_W'(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) chk("result_timeout", 1, 0);
        step();
    endtask

    task automatic chk_res(input string name, input int idx, input int ey, input bit es);
        if (idx < res_y.size()) begin
            chk({name, "_lit_y"}, res_y[idx], ey);
            chk({name, "_lit_sat"}, res_s[idx], es);
        end else begin
            chk({name, "_lit_missing"}, res_y.size(), idx + 1);
        end
    endtask

    task automatic clear_res();
        res_y.delete();
        res_s.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        d_in        = '0;
        coef_we     = 1'b0;
        coef_addr   = '0;
        coef_wdata  = '0;
        coef_commit = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_y", y, 0);
        chk("reset_y_valid", y_valid, 0);
        chk("reset_sat", sat, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        model_reset();
        started = 1'b1;

        // Passthrough with reset coefficients
        clear_res();
        send(100);
        send(-200);
        send(2047);
        wait_done();
        chk_res("pass0", 0, 100, 0);
        chk_res("pass1", 1, -200, 0);
        chk_res("pass2", 2, 2047, 0);

        // Impulse response
        do_flush();
        set_coefs(512, -256, 128, 1024);
        clear_res();
        send(1000);
        send(0);
        send(0);
        send(0);
        send(0);
        wait_done();
        chk_res("imp0", 0, 500, 0);
        chk_res("imp1", 1, -250, 0);
        chk_res("imp2", 2, 125, 0);
        chk_res("imp3", 3, 1000, 0);
        chk_res("imp4", 4, 0, 0);

        // Positive and negative saturation
        do_flush();
        set_coefs(1024, 1024, 0, 0);
        clear_res();
        send(2000);
        send(2000);
        wait_done();
        do_flush();
        send(-2048);
        send(-2048);
        wait_done();
        chk_res("satp0", 0, 2000, 0);
        chk_res("satp1", 1, 2047, 1);
        chk_res("satn0", 2, -2048, 0);
        chk_res("satn1", 3, -2048, 1);

        // Floor on the arithmetic shift: -3 * 0.5 -> -2
        do_flush();
        set_coefs(512, 0, 0, 0);
        clear_res();
        send(-3);
        wait_done();
        chk_res("floor", 0, -2, 0);

        // Commit while busy: current sample keeps c0=0.5, next uses c0=2047
        // (2.0 is not representable in 12-bit Q1.10; 2047/1024 is the max).
        clear_res();
        send(40);
        wr_coef(0, 2047);
        commit();
        wait_done();
        repeat (2) step();
        send(100);
        wait_done();
        chk_res("busy_old", 0, 20, 0);
        chk_res("busy_new", 1, 199, 0);

        // Flush mid-MAC (k = 2): no result, ready next cycle, history gone
        set_coefs(1024, 0, 0, 0);
        clear_res();
        send(9);
        step();
        step();
        do_flush();
        chk("flush_in_ready", in_ready, 1);
        send(50);
        wait_done();
        chk("flush_result_count", res_y.size(), 1);
        chk_res("flush_next", 0, 50, 0);

        // Asynchronous reset mid-MAC with non-default coefficients
        set_coefs(2047, 0, 0, 0);
        send(33);
        step();
        step();
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_y", y, 0);
        chk("arst_y_valid", y_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        ready_at = edge_n;
        clear_res();
        send(7);
        wait_done();
        chk_res("arst_next", 0, 7, 0);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
